div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Sequential restoring divider; the inverse of the team's shift-and-add multiplier.
- Divides a 2N-bit dividend, such as a multiplier product, by an N-bit divisor.
- Produces an N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and uses the same LOAD-style operand capture, plus a BUSY/VALID handshake and an error flag.

Parameters:
- PAYLOAD_BITS, default 8: N, the operand width. Divisor, quotient and remainder are N bits; the dividend is 2N bits. Legal range 2..32.

Ports:
- CLK_I  in  1  clock, rising edge.
- RST_N_I  in  1  asynchronous reset, active-low.
- LOAD_I  in  1  start request; operands sampled when high and BUSY_O low.
- DIVIDEND_I  in  2N  dividend, unsigned.
- DIVISOR_I  in  N  divisor, unsigned.
- BUSY_O  out  1  high while a division is in progress.
- VALID_O  out  1  one-cycle pulse; QUOT_O, REM_O and ERR_O are updated this cycle.
- QUOT_O  out  N  quotient.
- REM_O  out  N  remainder.
- ERR_O  out  1  overflow or divide-by-zero for the result presented with VALID_O.

Behaviour:
- Reset (async, RST_N_I low):
  - state=IDLE; BUSY_O=0, VALID_O=0, QUOT_O=0, REM_O=0, ERR_O=0.
  - Internal operand, partial-remainder and counter registers cleared.
  - Reset mid-division aborts it with no VALID_O.
- States:
  - IDLE: waits for LOAD_I.
    - LOAD_I=1 sampled at edge t0 with DIVIDEND_I[2N-1:N] >= DIVISOR_I (this covers DIVISOR_I=0): stay IDLE. At edge t0+1, VALID_O=1, ERR_O=1, QUOT_O=all ones, REM_O=0.
    - LOAD_I=1 otherwise: capture operands, partial remainder R = DIVIDEND_I[2N-1:N], count=N-1, go to CALC, BUSY_O=1 from edge t0.
  - CALC: one restoring step per edge.
    - T = {R, next dividend bit, MSB first}, width N+1.
    - If T >= divisor: R = T - divisor, quotient bit = 1; else R = T[N-1:0], quotient bit = 0.
    - count decrements each step.
    - The step with count=0 occurs at edge t0+N. At that edge: QUOT_O/REM_O take final values, VALID_O=1, ERR_O=0, BUSY_O=0, state goes to IDLE.
- Latency:
  - Normal division: N cycles from LOAD edge to VALID_O; throughput is one division per N cycles.
  - Error case: 1 cycle.
- Handshake:
  - LOAD_I while BUSY_O=1 is ignored; operands are not resampled and the current division is unaffected.
  - LOAD_I in the cycle VALID_O is high is accepted (BUSY_O is already 0), so back-to-back divisions are allowed.
- VALID_O is high for exactly one cycle per accepted LOAD.
- QUOT_O, REM_O and ERR_O hold their value until the next VALID_O; they are not cleared on LOAD.
- Width rules:
  - Comparison and subtraction are N+1 bits wide, and the no-overflow precondition guarantees R < divisor.
  - Results satisfy DIVIDEND = QUOT*DIVISOR + REM, with REM < DIVISOR.
- DIVIDEND_I and DIVISOR_I are don't-care outside accepted LOAD cycles.

Decomposition:
- Package div_pkg holds:
  - typedef enum logic [0:0] {IDLE, CALC} div_state_t;
  - localparam helpers for counter width, $clog2(PAYLOAD_BITS).
- Sub-module div_step: combinational single restoring step.
  - Inputs: R[N-1:0], dividend bit, divisor.
  - Outputs: next R, quotient bit.
  - Parameterised by PAYLOAD_BITS; div_seq instantiates it once.

Test Plan (N=8):
- Basic division: LOAD DIVIDEND_I=0x3039, DIVISOR_I=0x64 -> BUSY_O for 8 cycles; VALID_O at t0+8 with QUOT_O=0x7B, REM_O=0x2D, ERR_O=0.
- Maximum legal quotient: LOAD 0xFE01 / 0xFF -> QUOT_O=0xFF, REM_O=0x00, ERR_O=0 after 8 cycles.
- Error cases:
  - LOAD 0x0010 / 0x00 -> VALID_O at t0+1, ERR_O=1, QUOT_O=0xFF, REM_O=0x00, BUSY_O never high.
  - LOAD 0xFFFF / 0xFF -> same error response.
- Busy and back-to-back:
  - LOAD 0x0064 / 0x07, then LOAD 0x1234 / 0x01 at t0+3 -> second load ignored; result QUOT_O=0x0E, REM_O=0x02.
  - Then LOAD 0x00FF / 0x10 in the VALID_O cycle -> accepted; 8 cycles later QUOT_O=0x0F, REM_O=0x0F.
- Reset mid-operation: LOAD 0x3039 / 0x64, assert RST_N_I low at t0+4 asynchronously -> all outputs 0 immediately, no VALID_O after release. A new LOAD 0x0009 / 0x03 gives QUOT_O=0x03, REM_O=0x00.
- Random self-check: 1000 random operand pairs -> reference model checks DIVIDEND = QUOT*DIVISOR + REM and REM < DIVISOR, or ERR_O exactly when DIVIDEND_I[15:8] >= DIVISOR_I.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [0:0] {IDLE, CALC} div_state_t;

  localparam int DEFAULT_PAYLOAD_BITS = 8;

  // Step counter width; it has to hold PAYLOAD_BITS-1.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// Operand/result bundle between the datapath and the divider.
interface div_seq_if #(
  parameter int PAYLOAD_BITS = 8
);
  logic                      LOAD_I;
  logic [2*PAYLOAD_BITS-1:0] DIVIDEND_I;
  logic [PAYLOAD_BITS-1:0]   DIVISOR_I;
  logic                      BUSY_O;
  logic                      VALID_O;
  logic [PAYLOAD_BITS-1:0]   QUOT_O;
  logic [PAYLOAD_BITS-1:0]   REM_O;
  logic                      ERR_O;

  modport master (
    output LOAD_I, DIVIDEND_I, DIVISOR_I,
    input  BUSY_O, VALID_O, QUOT_O, REM_O, ERR_O
  );

  modport slave (
    input  LOAD_I, DIVIDEND_I, DIVISOR_I,
    output BUSY_O, VALID_O, QUOT_O, REM_O, ERR_O
  );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits.
module div_step #(
  parameter int PAYLOAD_BITS = 8
) (
  input  logic [PAYLOAD_BITS-1:0] r_i,
  input  logic                    bit_i,
  input  logic [PAYLOAD_BITS-1:0] divisor_i,
  output logic [PAYLOAD_BITS-1:0] r_o,
  output logic                    q_o
);
  logic [PAYLOAD_BITS:0]   t;
  logic [PAYLOAD_BITS-1:0] diff_lo;

  assign t       = {r_i, bit_i};
  assign q_o     = (t >= {1'b0, divisor_i});
  // The difference is below the divisor, so its low N bits are exact.
  assign diff_lo = t[PAYLOAD_BITS-1:0] - divisor_i;
  assign r_o     = q_o ? diff_lo : t[PAYLOAD_BITS-1:0];
endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one
// quotient bit per clock, with overflow / divide-by-zero flagged up front.
module div_seq
  import div_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS
) (
  input  logic     CLK_I,
  input  logic     RST_N_I,
  div_seq_if.slave bus
);
  localparam int N  = PAYLOAD_BITS;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

  div_state_t    state_q;
  logic [N-1:0]  r_q;        // partial remainder
  logic [N-1:0]  dvs_q;      // captured divisor
  logic [N-1:0]  sh_q;       // low dividend bits out the top, quotient bits in the bottom
  logic [CW-1:0] cnt_q;
  logic          err_pend_q; // overflow seen at LOAD, reported next cycle
  logic          busy_q, valid_q, err_q;
  logic [N-1:0]  quot_q, rem_q;

  logic [N-1:0]  r_d;
  logic          qbit_d;
  logic          ovf_d;

  div_step #(.PAYLOAD_BITS(N)) u_step (
    .r_i      (r_q),
    .bit_i    (sh_q[N-1]),
    .divisor_i(dvs_q),
    .r_o      (r_d),
    .q_o      (qbit_d)
  );

  // Quotient would not fit in N bits (includes divisor == 0).
  assign ovf_d = (bus.DIVIDEND_I[2*N-1:N] >= bus.DIVISOR_I);

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= IDLE;
      r_q        <= '0;
      dvs_q      <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      quot_q     <= '0;
      rem_q      <= '0;
    end else begin
      valid_q    <= 1'b0;
      err_pend_q <= 1'b0;
      if (err_pend_q) begin
        valid_q <= 1'b1;
        err_q   <= 1'b1;
        quot_q  <= '1;
        rem_q   <= '0;
      end
      case (state_q)
        IDLE: begin
          if (bus.LOAD_I) begin
            if (ovf_d) begin
              err_pend_q <= 1'b1;
            end else begin
              r_q     <= bus.DIVIDEND_I[2*N-1:N];
              sh_q    <= bus.DIVIDEND_I[N-1:0];
              dvs_q   <= bus.DIVISOR_I;
              cnt_q   <= CNT_INIT;
              busy_q  <= 1'b1;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= r_d;
          sh_q  <= {sh_q[N-2:0], qbit_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            valid_q <= 1'b1;
            err_q   <= 1'b0;
            quot_q  <= {sh_q[N-2:0], qbit_d};
            rem_q   <= r_d;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSY_O  = busy_q;
  assign bus.VALID_O = valid_q;
  assign bus.QUOT_O  = quot_q;
  assign bus.REM_O   = rem_q;
  assign bus.ERR_O   = err_q;
endmodule

// File: tb/tb_div_seq.sv
// Directed and randomised checks of div_seq at PAYLOAD_BITS = 8.
module tb_div_seq;
  localparam int N = 8;

  logic CLK_I   = 1'b0;
  logic RST_N_I = 1'b0;
  int   cyc     = 0;
  int   t0      = 0;
  int   checks  = 0;
  int   errors  = 0;

  div_seq_if #(.PAYLOAD_BITS(N)) bus ();

  div_seq #(.PAYLOAD_BITS(N)) dut (
    .CLK_I  (CLK_I),
    .RST_N_I(RST_N_I),
    .bus    (bus)
  );

  always #5 CLK_I = ~CLK_I;
  always @(posedge CLK_I) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a LOAD for one edge; returns #1 after that edge (t0).
  task automatic do_load(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs);
    bus.LOAD_I     = 1'b1;
    bus.DIVIDEND_I = dvd;
    bus.DIVISOR_I  = dvs;
    @(posedge CLK_I);
    #1;
    t0         = cyc;
    bus.LOAD_I = 1'b0;
  endtask

  // Wait (bounded) for VALID_O; latency is counted from t0.
  task automatic wait_valid(output int lat, output bit saw_busy);
    saw_busy = 1'b0;
    do begin
      @(posedge CLK_I);
      #1;
      if (bus.BUSY_O) saw_busy = 1'b1;
    end while (!bus.VALID_O && (cyc - t0) < 20);
    lat = cyc - t0;
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input logic [N-1:0] q, input logic [N-1:0] r, input logic e);
    check({tag, "_lat"},  lat,        exp_lat);
    check({tag, "_quot"}, bus.QUOT_O, q);
    check({tag, "_rem"},  bus.REM_O,  r);
    check({tag, "_err"},  bus.ERR_O,  e);
  endtask

  initial begin
    int          lat;
    bit          sb;
    bit          seen;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic        exp_e;

    bus.LOAD_I     = 1'b0;
    bus.DIVIDEND_I = '0;
    bus.DIVISOR_I  = '0;

    // Reset values.
    repeat (2) @(posedge CLK_I);
    #1;
    check("rst_busy",  bus.BUSY_O,  0);
    check("rst_valid", bus.VALID_O, 0);
    check("rst_quot",  bus.QUOT_O,  0);
    check("rst_rem",   bus.REM_O,   0);
    check("rst_err",   bus.ERR_O,   0);
    @(negedge CLK_I);
    RST_N_I = 1'b1;
    @(posedge CLK_I);
    #1;

    // Basic division: 12345 / 100 = 123 r 45.
    do_load(16'h3039, 8'h64);
    check("basic_busy_t0", bus.BUSY_O, 1);
    wait_valid(lat, sb);
    check_result("basic", lat, 8, 8'h7B, 8'h2D, 1'b0);
    check("basic_busy_end", bus.BUSY_O, 0);
    @(posedge CLK_I);
    #1;
    check("basic_valid_pulse", bus.VALID_O, 0);

    // Largest quotient that still fits.
    do_load(16'hFE01, 8'hFF);
    wait_valid(lat, sb);
    check_result("maxq", lat, 8, 8'hFF, 8'h00, 1'b0);

    // Divide by zero.
    do_load(16'h0010, 8'h00);
    check("div0_busy_t0", bus.BUSY_O, 0);
    wait_valid(lat, sb);
    check_result("div0", lat, 1, 8'hFF, 8'h00, 1'b1);
    check("div0_busy_seen", sb, 0);

    // Overflow with the high half equal to the divisor.
    do_load(16'hFFFF, 8'hFF);
    wait_valid(lat, sb);
    check_result("ovf", lat, 1, 8'hFF, 8'h00, 1'b1);
    check("ovf_busy_seen", sb, 0);

    // LOAD while busy is ignored: 100 / 7 = 14 r 2.
    do_load(16'h0064, 8'h07);
    repeat (2) @(posedge CLK_I);
    #1;
    bus.LOAD_I     = 1'b1;
    bus.DIVIDEND_I = 16'h1234;
    bus.DIVISOR_I  = 8'h01;
    @(posedge CLK_I);
    #1;
    bus.LOAD_I = 1'b0;
    check("busy_ign_busy", bus.BUSY_O, 1);
    wait_valid(lat, sb);
    check_result("busy_ign", lat, 8, 8'h0E, 8'h02, 1'b0);

    // Back-to-back LOAD in the VALID cycle: 255 / 16 = 15 r 15.
    do_load(16'h00FF, 8'h10);
    check("b2b_busy_t0",  bus.BUSY_O,  1);
    check("b2b_valid_t0", bus.VALID_O, 0);
    check("b2b_quot_hold", bus.QUOT_O, 8'h0E);
    wait_valid(lat, sb);
    check_result("b2b", lat, 8, 8'h0F, 8'h0F, 1'b0);

    // Asynchronous reset in the middle of a division.
    do_load(16'h3039, 8'h64);
    repeat (4) @(posedge CLK_I);
    #3;
    RST_N_I = 1'b0;
    #1;
    check("mrst_busy",  bus.BUSY_O,  0);
    check("mrst_valid", bus.VALID_O, 0);
    check("mrst_quot",  bus.QUOT_O,  0);
    check("mrst_rem",   bus.REM_O,   0);
    check("mrst_err",   bus.ERR_O,   0);
    #3;
    RST_N_I = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge CLK_I);
      #1;
      if (bus.VALID_O || bus.BUSY_O) seen = 1'b1;
    end
    check("mrst_no_valid", seen, 0);
    do_load(16'h0009, 8'h03);
    wait_valid(lat, sb);
    check_result("post_rst", lat, 8, 8'h03, 8'h00, 1'b0);

    // Random operands, half of them constrained to avoid overflow.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        dvs = 8'($urandom_range(1, 255));
        dvd = {8'($urandom_range(0, int'(dvs) - 1)), 8'($urandom_range(0, 255))};
      end else begin
        dvs = 8'($urandom_range(0, 255));
        dvd = 16'($urandom_range(0, 65535));
      end
      exp_e = (dvd[15:8] >= dvs);
      do_load(dvd, dvs);
      wait_valid(lat, sb);
      if (exp_e)
        check_result("rnd", lat, 1, 8'hFF, 8'h00, 1'b1);
      else
        check_result("rnd", lat, 8, 8'(dvd / 16'(dvs)), 8'(dvd % 16'(dvs)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
